// File: rtl/credit_bp_tx_if.sv
// Shared NoC defaults and the link interface carrying flits downstream and credits back upstream.
package noc_pkg;
  localparam int DEFAULT_VC_W          = 2;
  localparam int DEFAULT_D_W           = 32;
  localparam int DEFAULT_X_W           = 4;
  localparam int DEFAULT_Y_W           = 4;
  localparam int DEFAULT_VC_FIFO_DEPTH = 32;
endpackage

interface noc_if #(
  parameter int VC_W = noc_pkg::DEFAULT_VC_W,
  parameter int X_W  = noc_pkg::DEFAULT_X_W,
  parameter int Y_W  = noc_pkg::DEFAULT_Y_W,
  parameter int D_W  = noc_pkg::DEFAULT_D_W
) ();
  typedef struct packed {
    logic [X_W+Y_W-1:0] addr;
  } routeinfo_t;

  typedef struct packed {
    logic [D_W-1:0] data;
  } payload_t;

  typedef struct packed {
    routeinfo_t routeinfo;
    payload_t   payload;
  } packet_t;

  logic [VC_W-1:0] vc_target;
  packet_t         packet;
  logic [VC_W-1:0] vc_credit_gnt;

  modport transmitter (output vc_target, output packet, input vc_credit_gnt);
  modport receiver    (input vc_target, input packet, output vc_credit_gnt);
endinterface

// File: rtl/credit_bp_tx.sv
// Credit-based transmitter: per-VC credit counters gate flits from the switch onto the link
// and produce per-VC backpressure upstream; protocol violations raise a sticky error.
module credit_bp_tx
  import noc_pkg::*;
#(
  parameter int VC_W    = DEFAULT_VC_W,
  parameter int D_W     = DEFAULT_D_W,
  parameter int X_W     = DEFAULT_X_W,
  parameter int Y_W     = DEFAULT_Y_W,
  parameter int DEPTH   = DEFAULT_VC_FIFO_DEPTH,
  parameter int CREDITS = DEPTH - 1,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VC_W-1:0]       i_v,
  input  logic [X_W-1:0]        i_x,
  input  logic [Y_W-1:0]        i_y,
  input  logic [D_W-1:0]        i_d,
  output logic [VC_W-1:0]       o_b,
  noc_if.transmitter            to_tx,
  output logic                  o_err,
  output logic [VC_W*CNT_W-1:0] o_credit
);

  logic [CNT_W-1:0] cnt [VC_W];
  logic [VC_W-1:0]  full;
  logic [VC_W-1:0]  acc;
  logic             multi;

  always_comb begin
    o_b      = '0;
    full     = '0;
    o_credit = '0;
    // More than one bit set <=> clearing the lowest set bit leaves something behind.
    multi = |(i_v & (i_v - VC_W'(1)));
    for (int unsigned i = 0; i < VC_W; i++) begin
      o_b[i]                     = (cnt[i] == '0);
      full[i]                    = (cnt[i] == CNT_W'(CREDITS));
      o_credit[i*CNT_W +: CNT_W] = cnt[i];
    end
    acc = multi ? '0 : (i_v & ~o_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < VC_W; i++) cnt[i] <= CNT_W'(CREDITS);
      o_err                          <= 1'b0;
      to_tx.vc_target                <= '0;
      to_tx.packet.routeinfo.addr    <= '0;
      to_tx.packet.payload.data      <= '0;
    end else begin
      to_tx.vc_target <= acc;
      if (|acc) begin
        to_tx.packet.routeinfo.addr <= {i_x, i_y};
        to_tx.packet.payload.data   <= i_d;
      end
      // A credit returned to an already-full VC is dropped rather than overflowing the counter.
      if (multi || |(to_tx.vc_credit_gnt & full & ~acc)) o_err <= 1'b1;
      for (int unsigned i = 0; i < VC_W; i++) begin
        case ({acc[i], to_tx.vc_credit_gnt[i]})
          2'b10:   cnt[i] <= cnt[i] - CNT_W'(1);
          2'b01:   if (!full[i]) cnt[i] <= cnt[i] + CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: doc/credit_bp_tx.md
CREDIT_BP_TX -- requirements
Module: credit_bp_tx

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- VC_W, DEFAULT_VC_W: number of VCs.
- D_W, DEFAULT_D_W: payload width.
- X_W, DEFAULT_X_W: X address width.
- Y_W, DEFAULT_Y_W: Y address width.
- DEPTH, DEFAULT_VC_FIFO_DEPTH: downstream per-VC FIFO depth parameter.
- CREDITS, DEPTH-1: initial credits per VC.
- CNT_W, $clog2(DEPTH)+1: credit counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- i_v, in, VC_W: per-VC valid from switch output; at most one bit set.
- i_x, in, X_W: destination X of offered flit.
- i_y, in, Y_W: destination Y of offered flit.
- i_d, in, D_W: payload of offered flit.
- o_b, out, VC_W: per-VC backpressure (1 = no credit).
- to_tx, noc_if.transmitter, -: drives vc_target[VC_W], packet.routeinfo.addr[X_W+Y_W] and packet.payload.data[D_W]; samples vc_credit_gnt[VC_W].
- o_err, out, 1: sticky protocol-error flag.
- o_credit, out, VC_W*CNT_W: current credit count per VC, for debug.

Function
REQ-003 Per-VC counter cnt[i] SHALL hold available downstream slots, range 0..CREDITS.
REQ-004 o_b[i] SHALL be combinational and equal (cnt[i]==0); it does not depend on i_v.
REQ-005 A flit on VC i SHALL be accepted in a cycle iff i_v[i] & !o_b[i] & (i_v one-hot).
REQ-006 On acceptance, the next cycle SHALL drive vc_target=onehot(i), addr={i_x,i_y} and data=i_d (registered outputs, 1-cycle latency).
REQ-007 vc_target SHALL be 0 in every cycle after a cycle with no acceptance. addr and data SHALL hold their last values.
REQ-008 vc_target SHALL pulse for exactly one cycle per accepted flit; back-to-back acceptances give consecutive pulses.
REQ-009 Counter update per VC:
- accept only: cnt-1.
- vc_credit_gnt[i] only: cnt+1.
- both in the same cycle: unchanged.
- neither: hold.
REQ-010 A credit return arriving when cnt[i]==CREDITS (with no accept that cycle) SHALL leave cnt[i] unchanged and set o_err.
REQ-011 i_v with more than one bit set SHALL accept nothing that cycle and set o_err.
REQ-012 An offer on VC i while o_b[i]=1 SHALL NOT be accepted and SHALL NOT set o_err. The upstream holds the flit.
REQ-013 VCs SHALL be fully independent: exhaustion of VC i SHALL NOT affect o_b[j], j≠i.
REQ-014 o_err SHALL remain 1 until reset.
REQ-015 o_credit SHALL reflect registered cnt values.

Reset
REQ-016 While rst=1 at a clock edge:
- cnt[i] SHALL become CREDITS for all i.
- vc_target, o_err, addr and data SHALL become 0.
REQ-017 Out of reset, o_b SHALL be all-zero when CREDITS>0.
REQ-018 rst asserted mid-traffic SHALL discard any flit registered in the output stage (no vc_target pulse after reset) and restore full credits. Credit grants sampled during rst SHALL be ignored.
REQ-019 In the cycle after rst deasserts, the block SHALL accept flits normally.

Verification (VC_W=2, DEPTH=32, CREDITS=31)
REQ-020 Reset, then i_v=01 for 31 cycles with no grants -> 31 vc_target=01 pulses at cycles 2..32; cnt[0]=0 and o_b=01 after the 31st accept; 32nd offer held; o_b[1]=0.
REQ-021 VC0 exhausted, vc_credit_gnt=01 for one cycle -> cnt[0]=1 and o_b[0]=0 next cycle; one held flit accepted; cnt[0] returns to 0.
REQ-022 cnt[0]=5, accept on VC0 and vc_credit_gnt[0] in the same cycle -> cnt[0] stays 5; one vc_target=01 pulse with the correct addr/data.
REQ-023 i_v=11 -> no vc_target pulse, counters unchanged, o_err=1 and stays 1.
REQ-024 Full credits, vc_credit_gnt=10 -> cnt[1] stays 31, o_err=1.
REQ-025 Accept on VC1, then rst in the next cycle -> no vc_target pulse; both cnt return to 31; o_err=0.
